// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe board controller
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Cell index = row*3 + col, row-major with t11 at index 0.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Cursor step with wrap-around over 0..2.
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// rtl/ttt_win_check.sv - combinational three-in-a-row detector
// Ports:
//   board_i  [17:0] packed board, cell i at bits [2i+1:2i], row-major
//   player_i [1:0]  mark code to look for
//   win_o           high when any of the 8 lines holds player_i in all cells
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] board_i,
    input  logic [1:0]  player_i,
    output logic        win_o
);

    logic [1:0] cells [9];

    for (genvar g = 0; g < 9; g++) begin : g_unpack
        assign cells[g] = board_i[2*g +: 2];
    end

    always_comb begin
        win_o = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (cells[WIN_LINES[l][0]] == player_i &&
                cells[WIN_LINES[l][1]] == player_i &&
                cells[WIN_LINES[l][2]] == player_i) begin
                win_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_board_ctrl.sv
// rtl/ttt_board_ctrl.sv - tic-tac-toe game-state controller (board, cursor, turn, result)
// Optional macro TTT_TIMEOUT_EN: auto-move for the current player after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   new_game                        pulse, clears board and restarts
//   btn_up/down/left/right, btn_sel single-cycle button pulses
//   t11..t33 [1:0]                  cell states (00 empty, 01 P1, 10 P2)
//   cursor_row, cursor_col [1:0]    cursor position 0..2
//   turn                            0 = player 1 to move, 1 = player 2
//   illegal_move                    one-cycle pulse on a select of an occupied cell
//   game_over, winner [1:0], draw   game result, valid while in DONE
module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [1:0] t11,
    output logic [1:0] t12,
    output logic [1:0] t13,
    output logic [1:0] t21,
    output logic [1:0] t22,
    output logic [1:0] t23,
    output logic [1:0] t31,
    output logic [1:0] t32,
    output logic [1:0] t33,
    output logic [1:0] cursor_row,
    output logic [1:0] cursor_col,
    output logic       turn,
    output logic       illegal_move,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    state_t     state_q, state_d;
    cell_t      board_q [9];
    cell_t      board_d [9];
    logic [1:0] row_q, row_d, col_q, col_d;
    logic       turn_q, turn_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       over_q, over_d;
    logic [1:0] winner_q, winner_d;
    logic       draw_q, draw_d;

    logic [3:0]  cur_idx;
    cell_t       mover;
    logic [17:0] board_flat;
    logic        win;

    assign cur_idx = {2'b00, row_q} * 4'd3 + {2'b00, col_q};
    assign mover   = turn_q ? P2 : P1;

    always_comb begin
        board_flat = '0;
        for (int i = 0; i < 9; i++) begin
            board_flat[2*i +: 2] = board_q[i];
        end
    end

    // Evaluated on the registered board, so in CHECK it sees the mark just placed.
    ttt_win_check u_win_check (
        .board_i  (board_flat),
        .player_i (mover),
        .win_o    (win)
    );

`ifdef TTT_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        auto_found;
    logic [3:0]  auto_idx;
    logic [1:0]  auto_row, auto_col;
    logic        auto_hit;

    // First empty cell in row-major order.
    always_comb begin
        auto_found = 1'b0;
        auto_idx   = 4'd0;
        auto_row   = 2'd0;
        auto_col   = 2'd0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!auto_found && board_q[r*3 + c] == EMPTY) begin
                    auto_found = 1'b1;
                    auto_idx   = 4'(r*3 + c);
                    auto_row   = 2'(r);
                    auto_col   = 2'(c);
                end
            end
        end
    end

    assign auto_hit = (state_q == PLAY) && auto_found &&
                      (idle_q == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        col_d     = col_q;
        turn_d    = turn_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        over_d    = over_q;
        winner_d  = winner_q;
        draw_d    = draw_q;
`ifdef TTT_TIMEOUT_EN
        idle_d    = 32'd0;
`endif

        if (new_game) begin
            for (int i = 0; i < 9; i++) begin
                board_d[i] = EMPTY;
            end
            state_d  = PLAY;
            row_d    = 2'd1;
            col_d    = 2'd1;
            turn_d   = 1'b0;
            cnt_d    = 4'd0;
            over_d   = 1'b0;
            winner_d = 2'b00;
            draw_d   = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (btn_sel) begin
                        if (board_q[cur_idx] == EMPTY) begin
                            board_d[cur_idx] = mover;
                            cnt_d            = cnt_q + 4'd1;
                            state_d          = CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end else if (btn_up) begin
                        row_d = dec3(row_q);
                    end else if (btn_down) begin
                        row_d = inc3(row_q);
                    end else if (btn_left) begin
                        col_d = dec3(col_q);
                    end else if (btn_right) begin
                        col_d = inc3(col_q);
`ifdef TTT_TIMEOUT_EN
                    end else if (auto_hit) begin
                        board_d[auto_idx] = mover;
                        row_d             = auto_row;
                        col_d             = auto_col;
                        cnt_d             = cnt_q + 4'd1;
                        state_d           = CHECK;
                    end else begin
                        idle_d = idle_q + 32'd1;
`endif
                    end
                end
                CHECK: begin
                    if (win) begin
                        winner_d = mover;
                        over_d   = 1'b1;
                        state_d  = DONE;
                    end else if (cnt_q == MAX_MOVES) begin
                        draw_d  = 1'b1;
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                DONE: begin
                end
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                board_q[i] <= EMPTY;
            end
            state_q   <= PLAY;
            row_q     <= 2'd1;
            col_q     <= 2'd1;
            turn_q    <= 1'b0;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= 2'b00;
            draw_q    <= 1'b0;
`ifdef TTT_TIMEOUT_EN
            idle_q    <= 32'd0;
`endif
        end else begin
            board_q   <= board_d;
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            turn_q    <= turn_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            draw_q    <= draw_d;
`ifdef TTT_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign t11          = board_q[0];
    assign t12          = board_q[1];
    assign t13          = board_q[2];
    assign t21          = board_q[3];
    assign t22          = board_q[4];
    assign t23          = board_q[5];
    assign t31          = board_q[6];
    assign t32          = board_q[7];
    assign t33          = board_q[8];
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;
    assign turn         = turn_q;
    assign illegal_move = illegal_q;
    assign game_over    = over_q;
    assign winner       = winner_q;
    assign draw         = draw_q;

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Sequential game-state controller for the 3x3 tic-tac-toe VGA demo.
- Holds the nine 2-bit cell registers t11..t33 and drives them straight into the sprite decoder stage downstream.
- Takes debounced single-cycle button pulses, moves a cursor, places marks for alternating players, detects win/draw, and reports game status.

Parameters:
- TIMEOUT_CYCLES, 32'd250_000_000, idle cycles before an automatic move; used only with TTT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (VGA/pixel domain).
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  pulse; clears board, starts new game.
- btn_up, btn_down, btn_left, btn_right  in  1 each  pulse; move cursor.
- btn_sel  in  1  pulse; place current player's mark at cursor.
- t11,t12,t13,t21,t22,t23,t31,t32,t33  out  2 each  cell state; row/col numbered 1..3.
- cursor_row, cursor_col  out  2 each  cursor position, 0..2.
- turn  out  1  0 = player 1 to move, 1 = player 2.
- illegal_move  out  1  one-cycle pulse on a rejected select.
- game_over  out  1  high while in DONE.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- draw  out  1  high in DONE with no winner.

Behaviour:
- Cell encoding: 00 empty, 01 player 1, 10 player 2; 11 is never produced.
- Reset, when rst=1 at a clk edge:
  - all cells 00, cursor (1,1) (centre), turn 0, move_cnt 0;
  - illegal_move 0, game_over 0, winner 00, draw 0;
  - state PLAY.
- new_game has the same effect as rst and takes priority over every button in every state.
- FSM states: PLAY, CHECK, DONE.
- PLAY, btn_sel:
  - Cell at cursor empty: write (turn ? 10 : 01) into it; move_cnt+1; go to CHECK. The cell output updates the next cycle.
  - Cell occupied: board unchanged; illegal_move=1 for exactly one cycle; stay in PLAY.
- PLAY, movement:
  - up decrements the row, down increments it; left/right do the same for the column.
  - Wrap-around: 0->2 and 2->0.
  - Movement is allowed in PLAY only.
- Same-cycle priority: new_game > btn_sel > up > down > left > right. Only one action per cycle; lower-priority pulses are dropped.
- CHECK (exactly 1 cycle):
  - Evaluate the 8 lines (3 rows, 3 cols, 2 diagonals) on the registered board for the mover's code.
  - Win: winner = mover code, go to DONE.
  - Otherwise, move_cnt==9: draw=1, go to DONE.
  - Otherwise: toggle turn, go to PLAY.
  - Buttons are ignored in CHECK.
- DONE:
  - Board and cursor frozen; game_over=1.
  - Only new_game (or rst) leaves DONE.
  - A select in DONE does not pulse illegal_move.
- Latency: btn_sel at edge N -> cell visible after N+1 -> game_over/winner/draw and the toggled turn visible after N+2.
- A win on the 9th move reports the winner with draw=0.
- move_cnt is 4 bits and saturates logically at 9, because no select is accepted after DONE.
- All outputs are registered.

Optional Feature:
- Macro TTT_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter clears on any accepted action and on entering PLAY; it counts only in PLAY.
  - When it reaches TIMEOUT_CYCLES-1, the current player's mark is placed in the first empty cell in row-major order (t11 first) and the FSM goes to CHECK.
  - The cursor moves to that cell.
  - An auto-move never raises illegal_move.
  - Button actions in the same cycle take priority, and the counter restarts.
- Undefined: no counter logic exists; play waits indefinitely. The TIMEOUT_CYCLES parameter is present but unused.

Decomposition:
- Package ttt_pkg:
  - typedef cell_t (2-bit enum EMPTY/P1/P2);
  - typedef state_t (PLAY/CHECK/DONE);
  - constant WIN_LINES (8 triples of cell indices 0..8);
  - constant MAX_MOVES=9.
- Sub-module ttt_win_check: combinational; inputs a 9x2 board and a 2-bit player code; output 1-bit win (OR over the 8 line matches). It is instantiated once in CHECK evaluation.

Test Plan:
- Reset/defaults: assert rst for 2 cycles -> all t=00, cursor (1,1), turn 0, game_over 0, winner 00, draw 0.
- Wrap: from (1,1), pulse left twice -> col 2; up twice -> row 2; pulse up+right in the same cycle -> only the row changes.
- Illegal move: select at (1,1) -> t22=01 at N+1 and turn=1 at N+2; select again at (1,1) -> illegal_move high exactly 1 cycle, t22 still 01, turn stays 1.
- P1 row win: moves P1 (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) -> t11=t12=t13=01, winner 01, game_over 1, draw 0; further selects change nothing.
- Draw: sequence filling the board with no line, e.g. X O X / X O O / O X X -> after the 9th move draw=1, winner 00; new_game -> board cleared and turn 0.
- TTT_TIMEOUT_EN with TIMEOUT_CYCLES=16: after one P1 move at t11, stay idle 16 cycles -> t12=10 auto-placed, cursor (0,1), turn returns to 0.
